// File: rtl/cpu_div_pkg.sv
// Shared types and helpers for the iterative CPU divider.
package cpu_div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_t;

    // Conditional two's-complement negate; narrower callers zero-extend and truncate,
    // which stays correct modulo 2^WIDTH for any WIDTH <= DIV_W.
    function automatic logic [DIV_W-1:0] abs_w(input logic [DIV_W-1:0] val, input logic neg);
        return neg ? (~val + DIV_W'(1)) : val;
    endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, dvd_msb_i};
    assign diff    = shifted - {1'b0, dsr_i};

    // A set rem MSB means shifted >= 2^WIDTH > divisor, so the (WIDTH+1)-bit sign is unreliable there.
    assign q_bit_o = rem_i[WIDTH-1] | ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative radix-2 restoring divider for the M-stage: one quotient bit per clock,
// signed truncating or unsigned, fixed WIDTH+2 cycle latency.
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_byzero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_out_q, quot_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             bz_out_q, bz_out_d;
    logic             done_q, done_d;

    logic             sign1, sign2;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign sign1 = sgn_q & src1_q[WIDTH-1];
    assign sign2 = sgn_q & src2_q[WIDTH-1];

    cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dsr_i     (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (M_div_start) state_d = PREP;
            PREP:    state_d = ITER;
            ITER:    if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src1_d     = src1_q;
        src2_d     = src2_q;
        sgn_d      = sgn_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        bz_out_d   = bz_out_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (M_div_start) begin
                    src1_d = M_div_src1;
                    src2_d = M_div_src2;
                    sgn_d  = M_div_signed;
                end
            end
            PREP: begin
                dvd_d      = WIDTH'(abs_w(DIV_W'(src1_q), sign1));
                dsr_d      = WIDTH'(abs_w(DIV_W'(src2_q), sign2));
                rem_d      = '0;
                cnt_d      = '0;
                neg_quot_d = sign1 ^ sign2;
                neg_rem_d  = sign1;
                zero_d     = (src2_q == '0);
            end
            ITER: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                done_d   = 1'b1;
                bz_out_d = zero_q;
                if (zero_q) begin
                    quot_out_d = '1;
                    rem_out_d  = src1_q;
                end else begin
                    quot_out_d = WIDTH'(abs_w(DIV_W'(dvd_q), neg_quot_q));
                    rem_out_d  = WIDTH'(abs_w(DIV_W'(rem_q), neg_rem_q));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src1_q     <= '0;
            src2_q     <= '0;
            sgn_q      <= 1'b0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            bz_out_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            sgn_q      <= sgn_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            bz_out_q   <= bz_out_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        M_div_busy   = (state_q != IDLE);
        M_div_done   = done_q;
        M_div_quot   = quot_out_q;
        M_div_rem    = rem_out_q;
        M_div_byzero = bz_out_q;
    end

endmodule

// File: doc/cpu_div_cell.md
Name: cpu_div_cell

Overview:
- Iterative radix-2 restoring divider cell for the CPU M-stage. It is the inverse companion of the pipelined multiplier cell.
- Accepts a dividend and a divisor with a start pulse, runs one quotient bit per clock, and returns a quotient, a remainder and a divide-by-zero flag with a one-cycle done pulse.
- Supports signed and unsigned operation. Signed mode uses truncating semantics: quotient rounds toward zero, remainder takes the sign of the dividend.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- M_div_start  in  1  request pulse; sampled only in IDLE.
- M_div_signed  in  1  1 = two's-complement operands; captured with start.
- M_div_src1  in  WIDTH  dividend; captured with start.
- M_div_src2  in  WIDTH  divisor; captured with start.
- M_div_busy  out  1  high from the cycle after start is accepted until done.
- M_div_done  out  1  one-cycle pulse; results valid in that cycle.
- M_div_quot  out  WIDTH  quotient; held until the next done.
- M_div_rem  out  WIDTH  remainder; held until the next done.
- M_div_byzero  out  1  divisor was zero; held with the results.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, quot, rem and byzero all 0. Counter and working registers cleared. An operation in flight is abandoned and no done is produced.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 captures src1, src2 and signed; next state PREP; busy=1.
  - start=0 keeps IDLE.
- PREP (1 cycle):
  - Forms magnitudes |src1| and |src2|. Negation applies only when signed=1 and the operand MSB=1.
  - Records neg_q = sign1 XOR sign2 and neg_r = sign1.
  - Records byzero = (src2 == 0).
  - Clears the partial remainder; counter=0; next state ITER.
- ITER (exactly WIDTH cycles):
  - Shift {rem, dvd} left by 1.
  - Trial subtract: diff = rem_shifted - divisor_mag, computed at WIDTH+1 bits.
  - diff non-negative: rem = diff, quotient bit = 1.
  - diff negative: rem unchanged, quotient bit = 0.
  - Counter increments each cycle; when counter == WIDTH-1, next state FIX.
- FIX (1 cycle):
  - byzero=1: quot = all ones, rem = original src1 (unnegated).
  - Otherwise: quot = neg_q ? -q : q; rem = neg_r ? -r : r.
  - Registers the outputs, pulses done=1, busy=0, next state IDLE.
- Latency: start accepted at edge N gives done high in the cycle after edge N+WIDTH+2, i.e. WIDTH+2 cycles (34 at default). Latency is fixed and independent of operand values, including divide-by-zero.
- Signed overflow MIN / -1:
  - Magnitude 2^(WIDTH-1) is held as unsigned WIDTH bits.
  - Result: quot = MIN, rem = 0. No flag.
- Start while busy (PREP/ITER/FIX): ignored, no queuing, captured operands unaffected.
- Start in the done cycle: the FSM is in IDLE, so the start is accepted. done and the next busy are adjacent, allowing back-to-back operations.
- Operand inputs are don't-care except in the start cycle.
- The arithmetic datapath is a single WIDTH+1 subtractor. There are no multipliers and no combinational divide.

Decomposition:
- Shared package cpu_div_pkg:
  - state encoding typedef div_state_t {IDLE, PREP, ITER, FIX}.
  - localparam DIV_W = 32.
  - function abs_w (conditional two's-complement negate), reused by PREP and FIX.
- One natural sub-module, cpu_div_step:
  - Purely combinational: one restoring-division step.
  - Inputs: rem, dvd MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once inside the FSM datapath.
- All remaining logic (FSM, counter, sign fix-up, output registers) stays in cpu_div_cell.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> done at cycle 34; quot=14, rem=2, byzero=0. busy high cycles 1-33 and low at 34.
- Signed 0xFFFFFFF9 (-7) / 2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). Signed 7 / -2 -> quot=-3, rem=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0, byzero=0. Same operands unsigned -> quot=0, rem=0x80000000.
- Divide by zero: 5 / 0, either mode -> done at cycle 34; quot=0xFFFFFFFF, rem=5, byzero=1.
- Busy and back-to-back:
  - Start 9/4, then start again with 50/5 at cycle 10 -> second start ignored; results quot=2, rem=1.
  - Start 50/5 in the done cycle -> accepted; done 34 cycles later with quot=10, rem=0.
- Reset mid-op: start 1000/3, assert reset at cycle 12 for 2 cycles, no start afterwards -> outputs immediately 0, done never pulses, busy=0.
